// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue: entry layout and PC increments.
// No logic; no latency; no backpressure.
// Helper builds an entry with the upper half-word of compressed instructions cleared.
package fetch_queue_pkg;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic        compressed;
    } fq_entry_t;

    localparam logic [31:0] FQ_INCR_C = 32'd2;
    localparam logic [31:0] FQ_INCR_W = 32'd4;

    function automatic fq_entry_t fq_make_entry(input logic [31:0] insn,
                                                input logic [31:0] pc,
                                                input logic        compressed);
        fq_entry_t e;
        e.insn       = compressed ? {16'h0, insn[15:0]} : insn;
        e.pc         = pc;
        e.compressed = compressed;
        return e;
    endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Circular entry store with pointers and count; push/pop/flush, head always visible.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: caller must not push when full nor pop when empty; flush wins over both.
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  fq_entry_t                  wr_entry,
    output fq_entry_t                  head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fq_entry_t       entries [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: validity is tracked purely by count.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) entries[wr_ptr] <= wr_entry;
    end

    assign head  = entries[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue behind the fetch buffer; owns fetch PC, flushes on redirect.
// Latency: 1 cycle fetch-to-decode (0 with FETCH_QUEUE_BYPASS_EN defined, empty queue).
// Backpressure: fb_ren drops and fb_stall rises when full; decode pops with deq_valid/deq_ready.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
    input  logic                       CLK,
    input  logic                       RST,
    output logic [31:0]                fb_pc,
    output logic                       fb_ren,
    output logic                       fb_invalidate,
    output logic                       fb_stall,
    input  logic                       fb_insn_valid,
    input  logic                       fb_insn_compressed,
    input  logic [31:0]                fb_insn,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [31:0]                deq_insn,
    output logic [31:0]                deq_pc,
    output logic                       deq_compressed,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    logic [31:0]                fetch_pc;
    fq_entry_t                  in_entry;
    fq_entry_t                  head;
    fq_entry_t                  out_entry;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       bypass;
    logic                       mem_push;
    logic                       mem_pop;

    assign fb_pc         = fetch_pc;
    assign fb_ren        = !RST && !redirect && !full;
    assign fb_stall      = !RST && full;
    assign fb_invalidate = RST || redirect;
    assign push          = fb_ren && fb_insn_valid;
    assign in_entry      = fq_make_entry(fb_insn, fetch_pc, fb_insn_compressed);

`ifdef FETCH_QUEUE_BYPASS_EN
    // An empty queue hands the incoming instruction straight to decode when it is ready.
    assign bypass    = empty && push && deq_ready;
    assign deq_valid = !RST && (!empty || bypass);
    assign out_entry = bypass ? in_entry : head;
`else
    assign bypass    = 1'b0;
    assign deq_valid = !RST && !empty;
    assign out_entry = head;
`endif

    assign deq_insn       = out_entry.insn;
    assign deq_pc         = out_entry.pc;
    assign deq_compressed = out_entry.compressed;
    assign occupancy      = RST ? '0 : count;

    assign mem_push = push && !bypass;
    assign mem_pop  = deq_valid && deq_ready && !redirect && !empty;

    fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk      (CLK),
        .rst      (RST),
        .flush    (redirect),
        .push     (mem_push),
        .pop      (mem_pop),
        .wr_entry (in_entry),
        .head     (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & ~32'd1;
        end else if (push) begin
            fetch_pc <= fetch_pc + (fb_insn_compressed ? FQ_INCR_C : FQ_INCR_W);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue: a queue-based model predicts control
// outputs each cycle and the in-order stream of entries decode should receive.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0200;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc;
        logic        comp;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] fb_pc;
    logic        fb_ren, fb_invalidate, fb_stall;
    logic        fb_insn_valid, fb_insn_compressed;
    logic [31:0] fb_insn;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq_valid, deq_ready;
    logic [31:0] deq_insn, deq_pc;
    logic        deq_compressed;
    logic [$clog2(DEPTH+1)-1:0] occupancy;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        exp_q[$];
    int          mcount;
    logic [31:0] mpc;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK(CLK), .RST(RST), .fb_pc(fb_pc), .fb_ren(fb_ren),
        .fb_invalidate(fb_invalidate), .fb_stall(fb_stall),
        .fb_insn_valid(fb_insn_valid), .fb_insn_compressed(fb_insn_compressed),
        .fb_insn(fb_insn), .redirect(redirect), .redirect_pc(redirect_pc),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_insn(deq_insn),
        .deq_pc(deq_pc), .deq_compressed(deq_compressed), .occupancy(occupancy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every accepted head must be the oldest outstanding expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST === 1'b0 && redirect === 1'b0 && deq_valid === 1'b1 && deq_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("deq_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("deq_insn", deq_insn, e.insn);
                    check("deq_pc", deq_pc, e.pc);
                    check("deq_compressed", 32'(deq_compressed), 32'(e.comp));
                end
            end
        end
    end

    task automatic cycle(input bit rst, input bit redir, input logic [31:0] rpc,
                         input bit vld, input bit comp, input logic [31:0] insn,
                         input bit rdy);
        bit   e_ren, e_push, e_dv, e_pop, byp;
        exp_t e;
        @(posedge CLK);
        #1;
        RST = rst; redirect = redir; redirect_pc = rpc;
        fb_insn_valid = vld; fb_insn_compressed = comp; fb_insn = insn; deq_ready = rdy;
        e_ren  = !rst && !redir && (mcount != DEPTH);
        e_push = e_ren && vld;
        byp    = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp    = e_push && (mcount == 0) && rdy;
`endif
        e_dv   = !rst && ((mcount != 0) || byp);
        if (e_push) begin
            e.insn = comp ? (insn & 32'h0000_FFFF) : insn;
            e.pc   = mpc;
            e.comp = comp;
            exp_q.push_back(e);
        end
        @(negedge CLK);
        check("fb_ren", 32'(fb_ren), 32'(e_ren));
        check("fb_stall", 32'(fb_stall), 32'(!rst && (mcount == DEPTH)));
        check("fb_invalidate", 32'(fb_invalidate), 32'(rst || redir));
        check("fb_pc", fb_pc, mpc);
        check("occupancy", 32'(occupancy), rst ? 32'd0 : 32'(mcount));
        check("deq_valid", 32'(deq_valid), 32'(e_dv));
        e_pop = e_dv && rdy && !redir;
        if (rst) begin
            mcount = 0; mpc = RESET_PC; exp_q.delete();
        end else if (redir) begin
            mcount = 0; mpc = {rpc[31:1], 1'b0}; exp_q.delete();
        end else begin
            mcount = mcount + int'(e_push) - int'(e_pop);
            if (e_push) mpc = mpc + (comp ? 32'd2 : 32'd4);
        end
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, rdy);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        RST = 1'b1; redirect = 1'b0; redirect_pc = '0;
        fb_insn_valid = 1'b0; fb_insn_compressed = 1'b0; fb_insn = '0; deq_ready = 1'b0;
        mcount = 0; mpc = RESET_PC;

        do_reset();
        idle(1'b0);
        check("reset_pc", fb_pc, 32'h0000_0200);
        check("reset_occ", 32'(occupancy), 32'd0);

        // Fill with four words, decode stalled, then one more offered while full
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0010_0013 + 32'(i << 7), 1'b0);
        check("full_occ", 32'(occupancy), 32'd4);
        check("full_stall", 32'(fb_stall), 32'd1);
        check("full_ren", 32'(fb_ren), 32'd0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        idle(1'b0);
        check("after_pop_occ", 32'(occupancy), 32'd3);
        check("after_pop_ren", 32'(fb_ren), 32'd1);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Mixed C/W/C stream with junk above the compressed half-words, then a fetch gap
        do_reset();
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_4501, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h00A0_0093, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1234_8082, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b0);
        check("gap_pc", fb_pc, 32'h0000_0208);
        check("gap_occ", 32'(occupancy), 32'd3);

        // Redirect with three queued; that cycle's push and pop are discarded
        cycle(1'b0, 1'b1, 32'h0000_1003, 1'b1, 1'b0, 32'h0000_0013, 1'b1);
        idle(1'b0);
        check("redir_occ", 32'(occupancy), 32'd0);
        check("redir_dv", 32'(deq_valid), 32'd0);
        check("redir_pc", fb_pc, 32'h0000_1002);
        check("redir_ren", 32'(fb_ren), 32'd1);

        // Reset with two queued
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0113, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0001, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(1'b0);
        check("rst_mid_dv", 32'(deq_valid), 32'd0);
        check("rst_mid_pc", fb_pc, 32'h0000_0200);

        // Push into empty queue with decode ready (bypass case when enabled)
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0293, 1'b1);
        idle(1'b1);

        for (int i = 0; i < 400; i++)
            cycle($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom,
                  $urandom_range(3) != 0, 1'($urandom_range(1)), $urandom,
                  1'($urandom_range(1)));

        for (int i = 0; i < DEPTH + 3; i++) idle(1'b1);
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_occ", 32'(occupancy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, limit 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling instruction queue directly downstream of the RV32C fetch buffer. Owns the fetch PC and drives the fetch buffer's `pc`/`ren`/`invalidate`/`stall` inputs. Captures each instruction the fetch buffer produces together with its PC and compressed flag, and advances the PC by 2 or 4. Presents the queued instructions in order to decode with a valid/ready handshake, and flushes on a redirect from execute.

## Interface
Parameters:
- `DEPTH`, 4, number of queue entries; power of two, ≥ 2.
- `RESET_PC`, 32'h0000_0200, fetch PC loaded on reset.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `fb_pc`  out  32  fetch PC to the fetch buffer; equals the internal `fetch_pc` register.
- `fb_ren`  out  1  read request to the fetch buffer.
- `fb_invalidate`  out  1  clears the fetch buffer's held half-word.
- `fb_stall`  out  1  holds the fetch buffer's half-word because the queue is not accepting.
- `fb_insn_valid`  in  1  fetch buffer has an instruction this cycle.
- `fb_insn_compressed`  in  1  instruction is 16-bit.
- `fb_insn`  in  32  instruction; only bits [15:0] are meaningful when compressed.
- `redirect`  in  1  control-flow redirect from execute.
- `redirect_pc`  in  32  redirect target; bit 0 is ignored.
- `deq_valid`  out  1  head entry valid.
- `deq_ready`  in  1  decode accepts the head entry.
- `deq_insn`  out  32  head instruction; bits [31:16] are zero for compressed entries.
- `deq_pc`  out  32  head PC.
- `deq_compressed`  out  1  head is 16-bit.
- `occupancy`  out  $clog2(DEPTH+1)  number of valid entries.

## Operation
- State: `fetch_pc`, `wr_ptr`/`rd_ptr` of log2(DEPTH) bits each, `count`, and the entry array.
- `fb_ren = !RST && !redirect && (count != DEPTH)`. There is no combinational path from `deq_ready` to `fb_ren`.
- `fb_stall = (count == DEPTH)`.
- `fb_invalidate = RST || redirect`.
- **Push:** `push = fb_ren && fb_insn_valid`.
  - Write `{compressed ? {16'h0, fb_insn[15:0]} : fb_insn, fetch_pc, fb_insn_compressed}` at `wr_ptr`.
  - `wr_ptr` increments and wraps modulo DEPTH.
  - `fetch_pc` increases by 2 if compressed, else by 4. The add is 32-bit and wraps modulo 2^32.
- **No-instruction cycle:** `fb_ren && !fb_insn_valid`, e.g. an I$ miss or a misaligned 32-bit first half. `fetch_pc` holds and nothing is written.
- **Pop:** `pop = deq_valid && deq_ready && !redirect`.
  - `rd_ptr` increments and wraps modulo DEPTH.
  - `deq_*` always reflect the entry at `rd_ptr`.
  - `deq_valid = (count != 0)`.
- **Count update:**
  - Simultaneous push and pop leaves `count` unchanged.
  - A push while full cannot occur, because `fb_ren` is 0.
  - A pop while empty cannot occur.
- **Redirect (highest priority):** the next state is `count=0`, `wr_ptr=rd_ptr=0`, `fetch_pc={redirect_pc[31:1],1'b0}`. That cycle's push and pop are discarded. `deq_valid` may still be 1 during the redirect cycle, but decode must ignore it.
- **Reset:**
  - Next state is `fetch_pc=RESET_PC` and pointers/count zero.
  - Outputs while `RST` is high: `fb_ren=0`, `fb_invalidate=1`, `fb_stall=0`, `deq_valid=0`, `occupancy=0`.
  - Asserting RST mid-operation discards all entries within one cycle.

## Timing
- Accept to `deq_valid`: 1 cycle (entry registered), unless bypass is enabled.
- Pop to a freed slot visible on `fb_ren`: 1 cycle.
- Redirect to first fetch at the new PC: `fb_ren=1` with `fb_pc=redirect_pc` in the cycle after redirect.
- Sustained throughput: one instruction per cycle while the queue is neither full nor empty.

## Configuration
- Macro: `FETCH_QUEUE_BYPASS_EN`.
- **Defined:** when `count==0`, `push` and `deq_ready` are all true, the incoming instruction is driven combinationally on `deq_*` with `deq_valid=1`. It is consumed without being written, and `count` stays 0. This gives zero-cycle latency.
- **Undefined:** no bypass. Minimum latency is 1 cycle, and `deq_*` depend only on registers.

## Structure
- `fetch_queue_pkg` holds:
  - `typedef struct packed { logic [31:0] insn; logic [31:0] pc; logic compressed; } fq_entry_t;`
  - constants `FQ_INCR_C = 32'd2` and `FQ_INCR_W = 32'd4`.
- Sub-module `fetch_queue_mem` holds the entry array, pointers and count, with push/pop/flush inputs and head output. The top level owns `fetch_pc`, fetch-buffer control and the bypass mux.

## Test plan
- Reset then `fb_insn_valid` every cycle with four 32-bit instructions, `deq_ready=0`:
  - `deq_pc` = 0x200, 0x204, 0x208, 0x20C in order.
  - `occupancy` reaches 4, then `fb_ren=0` and `fb_stall=1`.
- Mixed stream C, W, C (compressed 0x4501, word 0x00A00093, compressed 0x8082):
  - PCs 0x200, 0x202, 0x206.
  - `deq_insn` = 0x00004501, 0x00A00093, 0x00008082.
- `fb_insn_valid=0` for 3 cycles mid-stream: `fb_pc` holds and `occupancy` is unchanged.
- Full queue, `deq_ready=1` for one cycle: `occupancy` 4→3, and `fb_ren` goes high the next cycle.
- Redirect to 0x1003 with 3 entries queued:
  - next cycle `occupancy=0`, `deq_valid=0`, `fb_pc=0x1002`.
  - `fb_invalidate=1` during the redirect cycle.
- Reset asserted while 2 entries are queued: next cycle `deq_valid=0` and `fb_pc=0x200`. With `FETCH_QUEUE_BYPASS_EN` defined, a push into the empty queue with `deq_ready=1` shows `deq_valid=1` in the same cycle.
